// File: rtl/proj_out_streamer.sv
// Receive-side endpoint of proj_unit: captures one Q/K/V bundle, requantizes every
// element (round-half-up shift + saturate) and streams it head-by-head on valid/ready.
module proj_out_streamer #(
    parameter int N      = 16,
    parameter int DW     = 4,
    parameter int PE_NUM = 12,
    parameter int SHIFT  = 3,
    parameter int OUT_W  = 4,
    localparam int ACC_W = 2 * DW + $clog2(N),
    localparam int HW    = $clog2(PE_NUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PE_NUM*ACC_W-1:0]   in_q,
    input  logic [PE_NUM*ACC_W-1:0]   in_k,
    input  logic [PE_NUM*ACC_W-1:0]   in_v,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [HW-1:0]             m_head,
    output logic [OUT_W-1:0]          m_q,
    output logic [OUT_W-1:0]          m_k,
    output logic [OUT_W-1:0]          m_v,
    output logic                      m_last,
    output logic [7:0]                sat_cnt,
    output logic                      ovr_err,
    input  logic                      clr
);

    localparam int NE = 3 * PE_NUM;
    localparam logic signed [ACC_W:0] RND  = (ACC_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2 ** (OUT_W - 1)));

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          head_q, head_d;
    logic [NE*OUT_W-1:0]    elem_q, elem_d;
    logic [7:0]             sat_cnt_q, sat_cnt_d;
    logic                   ovr_q, ovr_d;

    logic [NE*ACC_W-1:0]    in_all;
    logic [NE*OUT_W-1:0]    req_flat;
    logic [NE-1:0]          sat_vec;
    int                     sat_tot;

    // Element order in the flat vectors: all Q heads, then all K, then all V.
    assign in_all = {in_v, in_k, in_q};

    genvar gi;
    generate
        for (gi = 0; gi < NE; gi++) begin : g_req
            logic signed [ACC_W:0] ext;
            logic signed [ACC_W:0] t;
            // One guard bit keeps the rounding add from wrapping at the positive limit.
            assign ext = {in_all[gi*ACC_W + ACC_W - 1], in_all[gi*ACC_W +: ACC_W]};
            assign t   = (ext + RND) >>> SHIFT;
            assign sat_vec[gi] = (t > MAXV) || (t < MINV);
            assign req_flat[gi*OUT_W +: OUT_W] = (t > MAXV) ? MAXV[OUT_W-1:0] :
                                                 (t < MINV) ? MINV[OUT_W-1:0] :
                                                              t[OUT_W-1:0];
        end
    endgenerate

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        elem_d    = elem_q;
        sat_cnt_d = sat_cnt_q;
        ovr_d     = ovr_q;
        sat_tot   = int'(sat_cnt_q) + $countones(sat_vec);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d   = S_DRAIN;
                    head_d    = '0;
                    elem_d    = req_flat;
                    sat_cnt_d = (sat_tot > 255) ? 8'hFF : 8'(sat_tot);
                end
            end
            S_DRAIN: begin
                if (in_valid) begin
                    ovr_d = 1'b1;
                end
                if (m_ready) begin
                    if (head_q == HW'(PE_NUM - 1)) begin
                        state_d = S_IDLE;
                        head_d  = '0;
                    end else begin
                        head_d = head_q + HW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            sat_cnt_d = '0;
            ovr_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            elem_q    <= '0;
            sat_cnt_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            elem_q    <= elem_d;
            sat_cnt_q <= sat_cnt_d;
            ovr_q     <= ovr_d;
        end
    end

    assign in_ready = rst_n && (state_q == S_IDLE);
    assign m_valid  = (state_q == S_DRAIN);
    assign m_head   = head_q;
    assign m_last   = m_valid && (head_q == HW'(PE_NUM - 1));
    assign m_q      = elem_q[int'(head_q) * OUT_W +: OUT_W];
    assign m_k      = elem_q[(PE_NUM + int'(head_q)) * OUT_W +: OUT_W];
    assign m_v      = elem_q[(2 * PE_NUM + int'(head_q)) * OUT_W +: OUT_W];
    assign sat_cnt  = sat_cnt_q;
    assign ovr_err  = ovr_q;

endmodule
